gcd_arbiter: RTL

Round-robin arbiter and sequencer that shares one `gcd` calculator engine among N_REQ independent requesters. It accepts one (a, b) job at a time from the selected requester and issues it to the engine over the engine's valid/ready input handshake. It collects the result over the engine's output handshake and returns it to the originating requester only. It sits between the requester-side clients and a single `gcd` instance. The engine is driven from the same clk/rstn.

---
 rtl/gcd_arbiter.sv | 129 ++++++++++++
 1 files changed

// File: rtl/gcd_arbiter.sv
// gcd_arbiter: round-robin front end that shares a single gcd engine among
// N_REQ requesters, one job in flight at a time. The FSM walks
// ARB -> ISSUE -> WAIT -> RETURN -> ARB, and its state is exported on state_dbg.
//
// Handshake semantics, used on every interface of this block: a transfer
// happens on a rising clk edge where valid and ready are both high. A source
// holds valid and its payload stable until that transfer. Valid never waits on
// ready. Ready may depend combinationally on valid (req_ready does).
module gcd_arbiter #(
  parameter int N_REQ = 4,
  parameter int DW    = 8,
  localparam int GW   = $clog2(N_REQ)
) (
  input  logic                clk,
  input  logic                rstn,
  input  logic [N_REQ*DW-1:0] req_a,
  input  logic [N_REQ*DW-1:0] req_b,
  input  logic [N_REQ-1:0]    req_valid,
  output logic [N_REQ-1:0]    req_ready,
  output logic [DW-1:0]       rsp_gcd,
  output logic [N_REQ-1:0]    rsp_valid,
  input  logic [N_REQ-1:0]    rsp_ready,
  output logic [DW-1:0]       eng_a,
  output logic [DW-1:0]       eng_b,
  output logic                eng_valid,
  input  logic                eng_ready,
  input  logic [DW-1:0]       eng_gcd,
  input  logic                eng_res_valid,
  output logic                eng_res_ready,
  output logic                busy,
  output logic [GW-1:0]       grant_id,
  output logic [15:0]         done_cnt,
  output logic [1:0]          state_dbg
);

  localparam logic [1:0] ARB    = 2'd0;
  localparam logic [1:0] ISSUE  = 2'd1;
  localparam logic [1:0] WAIT   = 2'd2;
  localparam logic [1:0] RETURN = 2'd3;

  logic [1:0]    state;
  logic [GW-1:0] last_grant;
  logic [DW-1:0] op_a;
  logic [DW-1:0] op_b;

  // Round-robin search result
  logic          found;
  logic [GW-1:0] win;
  logic [GW:0]   rr_sum;
  logic [GW-1:0] rr_cand;

  // Scan requesters starting just after the last served one; first valid wins
  always_comb begin
    found   = 1'b0;
    win     = '0;
    rr_sum  = '0;
    rr_cand = '0;
    for (int i = 1; i <= N_REQ; i++) begin
      rr_sum = {1'b0, last_grant} + (GW+1)'(i);
      if (rr_sum >= (GW+1)'(N_REQ)) rr_sum = rr_sum - (GW+1)'(N_REQ);
      rr_cand = rr_sum[GW-1:0];
      if (!found && req_valid[rr_cand]) begin
        found = 1'b1;
        win   = rr_cand;
      end
    end
  end

  // Per-requester handshake vectors; forced low while reset is held
  always_comb begin
    req_ready = '0;
    rsp_valid = '0;
    if (rstn && state == ARB && found) req_ready[win] = 1'b1;
    if (rstn && state == RETURN) rsp_valid[grant_id] = 1'b1;
  end

  // Engine-side strobes and status, all decoded straight from the state
  always_comb begin
    eng_valid     = rstn && (state == ISSUE);
    eng_res_ready = rstn && (state == WAIT);
    busy          = rstn && (state != ARB);
    eng_a         = op_a;
    eng_b         = op_b;
    state_dbg     = state;
  end

  // Job sequencer: accept, issue to engine, collect result, return to owner
  always_ff @(posedge clk) begin
    if (!rstn) begin
      state      <= ARB;
      last_grant <= GW'(N_REQ-1);
      grant_id   <= '0;
      op_a       <= '0;
      op_b       <= '0;
      rsp_gcd    <= '0;
      done_cnt   <= '0;
    end else begin
      case (state)
        ARB: begin
          if (found) begin
            op_a     <= req_a[int'(win)*DW +: DW];
            op_b     <= req_b[int'(win)*DW +: DW];
            grant_id <= win;
            state    <= ISSUE;
          end
        end
        ISSUE: begin
          if (eng_ready) state <= WAIT;
        end
        WAIT: begin
          if (eng_res_valid) begin
            rsp_gcd <= eng_gcd;
            state   <= RETURN;
          end
        end
        RETURN: begin
          // Only the owner's rsp_ready completes the job
          if (rsp_ready[grant_id]) begin
            last_grant <= grant_id;
            done_cnt   <= done_cnt + 16'd1;
            state      <= ARB;
          end
        end
        default: state <= ARB;
      endcase
    end
  end

endmodule
